// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - 8N1 UART receiver feeding a little-endian instruction-memory loader
//
// Receives a byte stream on io_rx: 16-bit word count (low byte first), then
// count x 4 bytes of program data. Each group of 4 bytes is packed
// little-endian into one 32-bit word and written to instruction memory.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   io_rx      UART serial input, idle high, asynchronous to clk
//   mem_we     one-cycle instruction-memory write strobe
//   mem_addr   word address of the current write
//   mem_wdata  instruction word being written (holds last written word)
//   busy       a load is in progress
//   load_done  program fully loaded, sticky until reset
//   frame_err  a stop bit was sampled low, sticky until reset
module uart_program_loader #(
   parameter int CLK_FREQ   = 40_000_000,
   parameter int BAUD       = 115200,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  io_rx,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  busy,
   output logic                  load_done,
   output logic                  frame_err
);

   localparam int BIT_CNT  = CLK_FREQ / BAUD;
   localparam int HALF_CNT = BIT_CNT / 2;
   localparam int CW       = (BIT_CNT > 2) ? $clog2(BIT_CNT) : 1;
   localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CNT - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CNT - 1);

   // ------------------------------------------------------------------
   // Input synchronizer; resets to idle-high so reset release is quiet.
   // ------------------------------------------------------------------
   logic [1:0] sync_q;
   logic       rx_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= 2'b11;
      else          sync_q <= {sync_q[0], io_rx};
   end

   assign rx_s = sync_q[1];

   // ------------------------------------------------------------------
   // RX FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t     rx_state, rx_next;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_q;
   logic          tick;
   logic          stop_ok;
   logic          stop_bad;
   logic          byte_valid;
   logic [7:0]    byte_q;

   assign tick = (baud_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rx_state <= RX_IDLE;
      else          rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_s) rx_next = RX_START;
         RX_START: if (tick)  rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (tick && bit_idx == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (tick)  rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      if (rx_state == RX_STOP && tick) begin
         stop_ok  = rx_s;
         stop_bad = !rx_s;
      end
   end

   // Baud counter counts down to zero; each zero is a sample point.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_q    <= '0;
         byte_valid <= 1'b0;
         byte_q     <= '0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= stop_ok;
         if (stop_ok)  byte_q    <= shift_q;
         if (stop_bad) frame_err <= 1'b1;
         case (rx_state)
            RX_IDLE: begin
               baud_cnt <= HALF_LOAD;
               bit_idx  <= '0;
            end
            RX_START, RX_STOP: begin
               baud_cnt <= tick ? FULL_LOAD : baud_cnt - 1'b1;
            end
            RX_DATA: begin
               if (tick) begin
                  baud_cnt <= FULL_LOAD;
                  shift_q  <= {rx_s, shift_q[7:1]};
                  bit_idx  <= bit_idx + 1'b1;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            default: baud_cnt <= FULL_LOAD;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Loader FSM
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {L_LEN_LO, L_LEN_HI, L_WORD, L_WRITE, L_DONE} ld_state_t;

   ld_state_t   ld_state, ld_next;
   logic [15:0] word_total;
   logic [15:0] word_cnt;
   logic [1:0]  byte_idx;
   logic [23:0] asm_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ld_state <= L_LEN_LO;
      else          ld_state <= ld_next;
   end

   always_comb begin
      ld_next = ld_state;
      case (ld_state)
         L_LEN_LO: if (byte_valid) ld_next = L_LEN_HI;
         L_LEN_HI: if (byte_valid)
                      ld_next = ({byte_q, word_total[7:0]} == 16'd0) ? L_DONE : L_WORD;
         L_WORD:   if (byte_valid && byte_idx == 2'd3) ld_next = L_WRITE;
         L_WRITE:  ld_next = (word_cnt + 16'd1 == word_total) ? L_DONE : L_WORD;
         L_DONE:   ld_next = L_DONE;
         default:  ld_next = L_LEN_LO;
      endcase
   end

   always_comb begin
      mem_we    = (ld_state == L_WRITE);
      load_done = (ld_state == L_DONE);
      busy      = (ld_state == L_LEN_HI) || (ld_state == L_WORD) || (ld_state == L_WRITE);
   end

   // The first three bytes collect in asm_q so mem_wdata keeps the previous
   // word until the new one is complete.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_total <= '0;
         word_cnt   <= '0;
         byte_idx   <= '0;
         asm_q      <= '0;
         mem_wdata  <= '0;
         mem_addr   <= '0;
      end else begin
         case (ld_state)
            L_LEN_LO: if (byte_valid) word_total[7:0] <= byte_q;
            L_LEN_HI: if (byte_valid) begin
               word_total[15:8] <= byte_q;
               word_cnt         <= '0;
               byte_idx         <= '0;
               mem_addr         <= '0;
            end
            L_WORD: if (byte_valid) begin
               if (byte_idx == 2'd3) mem_wdata <= {byte_q, asm_q};
               else                  asm_q[{byte_idx, 3'b000} +: 8] <= byte_q;
               byte_idx <= byte_idx + 1'b1;
            end
            L_WRITE: begin
               mem_addr <= mem_addr + 1'b1;
               word_cnt <= word_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - self-checking bench for uart_program_loader
module tb_uart_program_loader;

   localparam int CLK_FREQ = 4_000_000;
   localparam int BAUD     = 100_000;
   localparam int BC       = CLK_FREQ / BAUD;
   localparam int HALF     = BC / 2;
   localparam int AW       = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          io_rx = 1'b1;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          busy;
   logic          load_done;
   logic          frame_err;

   uart_program_loader #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .io_rx    (io_rx),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .busy     (busy),
      .load_done(load_done),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic [7:0]    tx[$];
   logic [AW-1:0] obs_addr[$];
   logic [31:0]   obs_data[$];
   logic [AW-1:0] exp_addr[$];
   logic [31:0]   exp_data[$];
   logic          exp_done;
   logic          exp_busy;
   logic          we_prev = 1'b0;
   int            stop_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Write monitor: logs every strobe, checks pulse width and latency from
   // the start of the stop bit of the byte that completed the word.
   always @(negedge clk) begin
      if (mem_we) begin
         obs_addr.push_back(mem_addr);
         obs_data.push_back(mem_wdata);
         checks++;
         assert (!we_prev) else begin
            failures++;
            $error("FAIL we_width observed=multi-cycle expected=1");
         end
         checks++;
         assert ((cyc - stop_cyc) >= HALF + 2 && (cyc - stop_cyc) <= HALF + 6) else begin
            failures++;
            $error("FAIL we_latency observed=%0d expected=%0d..%0d", cyc - stop_cyc, HALF + 2, HALF + 6);
         end
      end
      we_prev = mem_we;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      io_rx = 1'b0;
      wait_clk(BC);
      for (int i = 0; i < 8; i++) begin
         io_rx = b[i];
         wait_clk(BC);
      end
      io_rx = stop_bit;
      stop_cyc = cyc;
      wait_clk(BC);
      io_rx = 1'b1;
   endtask

   task automatic send_range(input int first, input int last);
      for (int i = first; i <= last; i++) send_byte(tx[i], 1'b1);
   endtask

   // Reference model: what the stream in tx should have produced so far.
   task automatic model();
      int n, cnt, nw;
      exp_addr.delete();
      exp_data.delete();
      n = tx.size();
      cnt = (n >= 2) ? (int'(tx[0]) + 256 * int'(tx[1])) : 0;
      nw = (n >= 2) ? (n - 2) / 4 : 0;
      if (nw > cnt) nw = cnt;
      for (int k = 0; k < nw; k++) begin
         exp_data.push_back({tx[2+4*k+3], tx[2+4*k+2], tx[2+4*k+1], tx[2+4*k]});
         exp_addr.push_back(AW'(k % (1 << AW)));
      end
      exp_done = (n >= 2) && (nw == cnt);
      exp_busy = (n >= 1) && !exp_done;
   endtask

   task automatic compare(input string tag);
      model();
      chk({tag, "_nwrites"}, obs_data.size(), exp_data.size());
      for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
         chk($sformatf("%s_addr%0d", tag, k), 32'(obs_addr[k]), 32'(exp_addr[k]));
         chk($sformatf("%s_data%0d", tag, k), obs_data[k], exp_data[k]);
      end
      chk({tag, "_done"}, 32'(load_done), 32'(exp_done));
      chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      io_rx = 1'b1;
      wait_clk(3);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_flags", {29'd0, busy, load_done, frame_err}, 0);
      obs_addr.delete();
      obs_data.delete();
      tx.delete();
      reset_n = 1'b1;
      wait_clk(5);
   endtask

   initial begin
      // 1: single-word load from the example stream
      do_reset();
      tx = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
      send_range(0, 5);
      wait_clk(2 * BC);
      compare("one_word");
      if (obs_data.size() > 0) chk("one_word_literal", obs_data[0], 32'h00A00513);

      // 2: three random words; done only after the third write
      do_reset();
      tx = '{8'h03, 8'h00};
      for (int i = 0; i < 12; i++) tx.push_back(8'($urandom));
      send_range(0, 12);
      wait_clk(2 * BC);
      chk("three_mid_done", 32'(load_done), 0);
      chk("three_mid_writes", obs_data.size(), 2);
      send_range(13, 13);
      wait_clk(2 * BC);
      compare("three_words");

      // 3: short glitch is ignored, then an empty load completes
      do_reset();
      io_rx = 1'b0;
      wait_clk(HALF - 5);
      io_rx = 1'b1;
      wait_clk(2 * BC);
      chk("glitch_busy", 32'(busy), 0);
      chk("glitch_ferr", 32'(frame_err), 0);
      chk("glitch_writes", obs_data.size(), 0);
      tx = '{8'h00, 8'h00};
      send_range(0, 1);
      wait_clk(2 * BC);
      compare("empty");

      // 4: framing error drops the byte; following load still works
      do_reset();
      send_byte(8'h55, 1'b0);
      wait_clk(2 * BC);
      chk("ferr_set", 32'(frame_err), 1);
      chk("ferr_busy", 32'(busy), 0);
      tx = '{8'h01, 8'h00};
      for (int i = 0; i < 4; i++) tx.push_back(8'($urandom));
      send_range(0, 5);
      wait_clk(2 * BC);
      compare("after_ferr");
      chk("ferr_sticky", 32'(frame_err), 1);

      // 5: reset mid-load, then a fresh one-word load lands at address 0
      do_reset();
      tx = '{8'h02, 8'h00};
      for (int i = 0; i < 6; i++) tx.push_back(8'($urandom));
      send_range(0, 7);
      io_rx = 1'b0;
      wait_clk(3 * BC);
      wait_clk(2 * BC);
      compare("pre_abort");
      do_reset();
      for (int i = 0; i < 6; i++) tx.push_back((i < 2) ? ((i == 0) ? 8'h01 : 8'h00) : 8'($urandom));
      send_range(0, 5);
      wait_clk(2 * BC);
      compare("post_abort");

      // 6: five random words wrap the 4-deep address space; trailing bytes ignored
      do_reset();
      tx = '{8'h05, 8'h00};
      for (int i = 0; i < 20; i++) tx.push_back(8'($urandom));
      send_range(0, 21);
      wait_clk(2 * BC);
      compare("wrap");
      send_byte(8'($urandom), 1'b1);
      send_byte(8'($urandom), 1'b1);
      wait_clk(2 * BC);
      compare("wrap_trailing");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
